// File: rtl/cbus_ram_responder.sv
// cbus_pkg: request/response structures shared by CBus initiators and targets.
//
// cbus_ram_responder: synthesizable CBus target that serves single and burst
// reads/writes from an internal array of 64-bit words.
//   clk    in   rising-edge clock
//   reset  in   asynchronous reset, active low (0 = in reset)
//   creq   in   request: valid, is_write, size, addr, strobe, data, len, burst
//   cresp  out  response: ready, last, data
//   err    out  sticky error: out-of-range beat or valid dropped mid-transaction
//
// Transaction flow: IDLE accepts a request (its address/len/burst/direction are
// latched), WAIT burns LATENCY cycles, then BURST delivers len+1 beats with no
// bubbles and returns to IDLE. Write data and strobes are taken live on every
// beat. The RAM itself is never reset.

package cbus_pkg;

  // Encoded as beats-1 so the beat counter can be compared directly.
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } cbus_len_t;

  typedef enum logic {
    FIXED = 1'b0,
    INCR  = 1'b1
  } cbus_burst_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    cbus_len_t   len;
    cbus_burst_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

module cbus_ram_responder
  import cbus_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp,
  output logic       err
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST
  } state_t;

  state_t      state, state_nxt;
  logic        is_write_q, is_write_nxt;
  logic [3:0]  len_q, len_nxt;
  cbus_burst_t burst_q, burst_nxt;
  logic [3:0]  beat_cnt, beat_nxt;
  logic [3:0]  lat_cnt, lat_nxt;
  logic        err_nxt;
  logic [63:0] addr_q;
  logic        accept;
  logic        wr_en;

  logic [63:0] mem [MEM_WORDS];

  logic [63:0] word_off;
  logic [63:0] word_idx;
  logic        in_range;
  logic [AW-1:0] idx;

  // size is informational only: strobes alone select the bytes written.
  logic [2:0] unused_size;
  assign unused_size = creq.size;

  // Word index of the current beat. Computed on the full 64-bit offset so an
  // address far past the array can never alias back into it.
  always_comb begin
    word_off = (addr_q - BASE_ADDR) >> 3;
    word_idx = word_off + ((burst_q == INCR) ? {60'd0, beat_cnt} : 64'd0);
    in_range = (addr_q >= BASE_ADDR) && (word_idx < 64'(MEM_WORDS));
    idx      = word_idx[AW-1:0];
  end

  assign accept = (state == S_IDLE) && creq.valid;

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    is_write_nxt = is_write_q;
    len_nxt      = len_q;
    burst_nxt    = burst_q;
    beat_nxt     = beat_cnt;
    lat_nxt      = lat_cnt;
    err_nxt      = err;
    wr_en        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (creq.valid) begin
          is_write_nxt = creq.is_write;
          len_nxt      = creq.len;
          burst_nxt    = creq.burst;
          beat_nxt     = 4'd0;
          if (LATENCY == 0) begin
            state_nxt = S_BURST;
          end else begin
            state_nxt = S_WAIT;
            lat_nxt   = 4'(LATENCY);
          end
        end
      end
      S_WAIT: begin
        if (!creq.valid) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end else begin
          lat_nxt = lat_cnt - 4'd1;
          if (lat_cnt <= 4'd1) begin
            state_nxt = S_BURST;
          end
        end
      end
      S_BURST: begin
        if (!creq.valid) begin
          // Initiator abandoned the transaction: the current beat is not
          // committed, earlier write beats stay in the RAM.
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end else begin
          if (!in_range) begin
            err_nxt = 1'b1;
          end
          wr_en = is_write_q && in_range;
          if (beat_cnt == len_q) begin
            state_nxt = S_IDLE;
          end else begin
            beat_nxt = beat_cnt + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      is_write_q <= 1'b0;
      len_q      <= 4'd0;
      burst_q    <= FIXED;
      beat_cnt   <= 4'd0;
      lat_cnt    <= 4'd0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      is_write_q <= is_write_nxt;
      len_q      <= len_nxt;
      burst_q    <= burst_nxt;
      beat_cnt   <= beat_nxt;
      lat_cnt    <= lat_nxt;
      err        <= err_nxt;
    end
  end

  // Latched request address (datapath, no reset needed: only used in BURST)
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= creq.addr;
    end
  end

  // RAM write port: byte-granular, committed at the edge ending the beat
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (creq.strobe[i]) begin
          mem[idx][8*i +: 8] <= creq.data[8*i +: 8];
        end
      end
    end
  end

  // Response: driven purely from registered state so reset clears it at once
  always_comb begin
    cresp = '0;
    if (state == S_BURST) begin
      cresp.ready = 1'b1;
      cresp.last  = (beat_cnt == len_q);
      if (!is_write_q && in_range) begin
        cresp.data = mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_cbus_ram_responder.sv
module tb_cbus_ram_responder;
  import cbus_pkg::*;

  localparam int          MEM_WORDS = 1024;
  localparam logic [63:0] BASE      = 64'h8000_0000;
  localparam int          LAT       = 2;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  logic       err;

  always #5 clk = ~clk;

  cbus_ram_responder #(
    .MEM_WORDS(MEM_WORDS),
    .BASE_ADDR(BASE),
    .LATENCY  (LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .creq (creq),
    .cresp(cresp),
    .err  (err)
  );

  typedef struct {
    bit          chk_data;
    logic        last;
    logic [63:0] data;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       obs_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat_obs;
  logic [63:0] wdata [16];
  logic [7:0]  wstrb [16];

  function automatic void push_exp(input bit chk, input logic last, input logic [63:0] data);
    beat_t b;
    b.chk_data = chk;
    b.last     = last;
    b.data     = data;
    exp_q.push_back(b);
  endfunction

  // Drives one transaction and records every ready beat into obs_q.
  // chained: valid is already high in IDLE, so the request is presented now.
  // keep_valid: leave valid high after last for a back-to-back follower.
  task automatic xfer(input bit wr, input logic [63:0] addr, input cbus_len_t len,
                      input cbus_burst_t b, input bit chained, input bit keep_valid);
    int    beat = 0;
    int    cyc  = 0;
    bit    done = 0;
    beat_t o;
    lat_obs = -1;
    if (!chained) begin
      @(posedge clk); #1;
    end
    creq.valid    = 1'b1;
    creq.is_write = wr;
    creq.addr     = addr;
    creq.len      = len;
    creq.burst    = b;
    creq.size     = 3'd3;
    creq.data     = wdata[0];
    creq.strobe   = wstrb[0];
    @(posedge clk); #1;
    // Disturb the latched fields; the target must ignore them while busy.
    creq.addr     = addr ^ 64'h40;
    creq.len      = MLEN16;
    creq.is_write = ~wr;
    creq.burst    = (b == INCR) ? FIXED : INCR;
    while (!done && cyc < 100) begin
      @(negedge clk);
      if (cresp.ready) begin
        if (lat_obs < 0) lat_obs = cyc;
        o.chk_data = 1'b1;
        o.last     = cresp.last;
        o.data     = cresp.data;
        obs_q.push_back(o);
        beat++;
        if (cresp.last) done = 1;
      end
      cyc++;
      @(posedge clk); #1;
      if (!done && beat < 16) begin
        creq.data   = wdata[beat];
        creq.strobe = wstrb[beat];
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL xfer_timeout: no last beat within %0d cycles (addr=%h)", cyc, addr);
    end
    if (!keep_valid || !done) creq.valid = 1'b0;
  endtask

  task automatic test_reset();
    creq  = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (cresp.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", cresp.ready); end
    n_checks++;
    if (cresp.last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", cresp.last); end
    n_checks++;
    if (cresp.data !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", cresp.data); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    #2 reset = 1'b1;
  endtask

  task automatic test_single_read();
    beat_t e, o;
    wdata[0] = 64'hDEAD_BEEF_0123_4567; wstrb[0] = 8'hFF;
    push_exp(0, 1'b1, 64'h0);
    xfer(1, BASE, MLEN1, INCR, 0, 0);
    push_exp(1, 1'b1, 64'hDEAD_BEEF_0123_4567);
    xfer(0, BASE, MLEN1, INCR, 0, 0);
    n_checks++;
    if (lat_obs !== LAT) begin n_fail++; $display("FAIL single_latency: got %0d empty cycles want %0d", lat_obs, LAT); end
    @(negedge clk);
    n_checks++;
    if (cresp.ready !== 1'b0 || cresp.data !== 64'h0) begin
      n_fail++; $display("FAIL single_idle: ready=%b data=%h want ready=0 data=0", cresp.ready, cresp.data);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_beats: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.last !== e.last || (e.chk_data && o.data !== e.data)) begin
        n_fail++; $display("FAIL single_beat: last=%b data=%h want last=%b data=%h", o.last, o.data, e.last, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_incr_burst();
    beat_t e, o;
    for (int k = 0; k < 4; k++) begin
      wdata[k] = 64'h11 * (k + 1);
      wstrb[k] = 8'hFF;
      push_exp(0, (k == 3), 64'h0);
    end
    xfer(1, BASE + 64'd8, MLEN4, INCR, 0, 0);
    n_checks++;
    if (lat_obs !== LAT) begin n_fail++; $display("FAIL incr_wr_latency: got %0d want %0d", lat_obs, LAT); end
    for (int k = 0; k < 4; k++) push_exp(1, (k == 3), 64'h11 * (k + 1));
    xfer(0, BASE + 64'd8, MLEN4, INCR, 0, 0);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL incr_beats: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.last !== e.last || (e.chk_data && o.data !== e.data)) begin
        n_fail++; $display("FAIL incr_beat: last=%b data=%h want last=%b data=%h", o.last, o.data, e.last, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_partial_strobe();
    beat_t e, o;
    wdata[0] = 64'h0; wstrb[0] = 8'hFF;
    push_exp(0, 1'b1, 64'h0);
    xfer(1, BASE + 64'd40, MLEN1, INCR, 0, 0);
    wdata[0] = 64'hAABB_CCDD_EEFF_0011; wstrb[0] = 8'h0F;
    push_exp(0, 1'b1, 64'h0);
    xfer(1, BASE + 64'd40, MLEN1, INCR, 0, 0);
    push_exp(1, 1'b1, 64'h0000_0000_EEFF_0011);
    xfer(0, BASE + 64'd40, MLEN1, INCR, 0, 0);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL strobe_err: got %b want 0", err); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL strobe_beats: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.last !== e.last || (e.chk_data && o.data !== e.data)) begin
        n_fail++; $display("FAIL strobe_beat: last=%b data=%h want last=%b data=%h", o.last, o.data, e.last, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_fixed_burst();
    beat_t e, o;
    for (int k = 0; k < 4; k++) begin
      wdata[k] = 64'(k + 1);
      wstrb[k] = 8'hFF;
      push_exp(0, (k == 3), 64'h0);
    end
    xfer(1, BASE + 64'd16, MLEN4, FIXED, 0, 0);
    // RAM[2] ends with the last beat, RAM[3] keeps 0x33 from the INCR burst.
    push_exp(1, 1'b0, 64'h4);
    push_exp(1, 1'b1, 64'h33);
    xfer(0, BASE + 64'd16, MLEN2, INCR, 0, 0);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fixed_beats: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.last !== e.last || (e.chk_data && o.data !== e.data)) begin
        n_fail++; $display("FAIL fixed_beat: last=%b data=%h want last=%b data=%h", o.last, o.data, e.last, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    beat_t e, o;
    push_exp(1, 1'b0, 64'h33);
    push_exp(1, 1'b1, 64'h44);
    xfer(0, BASE + 64'd24, MLEN2, INCR, 0, 1);
    push_exp(1, 1'b1, 64'hDEAD_BEEF_0123_4567);
    xfer(0, BASE, MLEN1, INCR, 1, 1);
    n_checks++;
    if (lat_obs !== LAT) begin n_fail++; $display("FAIL b2b_rd_latency: got %0d want %0d", lat_obs, LAT); end
    wdata[0] = 64'h6666_0000_0000_0066; wstrb[0] = 8'hFF;
    push_exp(0, 1'b1, 64'h0);
    xfer(1, BASE + 64'd48, MLEN1, INCR, 1, 0);
    n_checks++;
    if (lat_obs !== LAT) begin n_fail++; $display("FAIL b2b_wr_latency: got %0d want %0d", lat_obs, LAT); end
    push_exp(1, 1'b1, 64'h6666_0000_0000_0066);
    xfer(0, BASE + 64'd48, MLEN1, INCR, 0, 0);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_beats: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.last !== e.last || (e.chk_data && o.data !== e.data)) begin
        n_fail++; $display("FAIL b2b_beat: last=%b data=%h want last=%b data=%h", o.last, o.data, e.last, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_out_of_range();
    beat_t e, o;
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL oor_err_before: got %b want 0", err); end
    push_exp(1, 1'b1, 64'h0);
    xfer(0, BASE + 64'(8 * MEM_WORDS), MLEN1, INCR, 0, 0);
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL oor_high_err: got %b want 1", err); end
    reset = 1'b0; #2;
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL oor_err_cleared: got %b want 0", err); end
    reset = 1'b1;
    push_exp(1, 1'b1, 64'h0);
    xfer(0, BASE - 64'd8, MLEN1, INCR, 0, 0);
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL oor_low_err: got %b want 1", err); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL oor_beats: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.last !== e.last || (e.chk_data && o.data !== e.data)) begin
        n_fail++; $display("FAIL oor_beat: last=%b data=%h want last=%b data=%h", o.last, o.data, e.last, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_protocol_violation();
    int cyc = 0;
    reset = 1'b0; #2; reset = 1'b1;
    @(posedge clk); #1;
    creq.valid = 1'b1; creq.is_write = 1'b0; creq.addr = BASE + 64'd8;
    creq.len = MLEN4; creq.burst = INCR;
    do begin
      @(negedge clk); cyc++;
    end while (!cresp.ready && cyc < 20);
    n_checks++;
    if (cresp.ready !== 1'b1) begin n_fail++; $display("FAIL viol_first_beat: ready=%b want 1", cresp.ready); end
    @(posedge clk); #1;
    creq.valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || cresp.ready !== 1'b1) begin
      n_fail++; $display("FAIL viol_same_cycle: err=%b ready=%b want err=0 ready=1", err, cresp.ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (err !== 1'b1 || cresp.ready !== 1'b0 || cresp.last !== 1'b0) begin
      n_fail++; $display("FAIL viol_abort: err=%b ready=%b last=%b want 1 0 0", err, cresp.ready, cresp.last);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (cresp.ready !== 1'b0 || err !== 1'b1) begin
      n_fail++; $display("FAIL viol_stays_idle: ready=%b err=%b want 0 1", cresp.ready, err);
    end
  endtask

  task automatic test_reset_mid_burst();
    beat_t e, o;
    int    cyc = 0;
    @(posedge clk); #1;
    creq.valid = 1'b1; creq.is_write = 1'b0; creq.addr = BASE;
    creq.len = MLEN8; creq.burst = INCR;
    do begin
      @(negedge clk); cyc++;
    end while (!cresp.ready && cyc < 20);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (cresp.ready !== 1'b1 || err !== 1'b1) begin
      n_fail++; $display("FAIL mid_beat2: ready=%b err=%b want 1 1", cresp.ready, err);
    end
    reset = 1'b0; #1;
    n_checks++;
    if (cresp.ready !== 1'b0 || cresp.last !== 1'b0 || cresp.data !== 64'h0 || err !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: ready=%b last=%b data=%h err=%b want all 0",
                         cresp.ready, cresp.last, cresp.data, err);
    end
    creq.valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cresp.ready !== 1'b0) begin n_fail++; $display("FAIL mid_idle: ready=%b want 0", cresp.ready); end
    push_exp(1, 1'b1, 64'hDEAD_BEEF_0123_4567);
    xfer(0, BASE, MLEN1, INCR, 0, 0);
    n_checks++;
    if (lat_obs !== LAT) begin n_fail++; $display("FAIL mid_after_latency: got %0d want %0d", lat_obs, LAT); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_beats: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.last !== e.last || (e.chk_data && o.data !== e.data)) begin
        n_fail++; $display("FAIL mid_beat: last=%b data=%h want last=%b data=%h", o.last, o.data, e.last, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      wdata[k] = 64'h0;
      wstrb[k] = 8'h00;
    end
    test_reset();
    test_single_read();
    test_incr_burst();
    test_partial_strobe();
    test_fixed_burst();
    test_back_to_back();
    test_out_of_range();
    test_protocol_violation();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
